// File: rtl/noc_output_allocator_if.sv
// Flit handshake between the input ports and one router output port.
// Valid/ready: an input's flit moves when req_i[i] & grant_o[i] & out_ready_i
// are all high at a rising clock edge. grant_o doubles as the data-mux select
// and, ANDed with out_ready_i, as each input's ready. A presented flit (and its
// head/tail flags) must stay unchanged until it moves.
interface noc_output_allocator_if #(
    parameter int N_REQ = 5
);
    logic [N_REQ-1:0] req_i;
    logic [N_REQ-1:0] head_i;
    logic [N_REQ-1:0] tail_i;
    logic             out_ready_i;
    logic [N_REQ-1:0] grant_o;
    logic             out_valid_o;

    // Input-port / downstream side.
    modport master (
        output req_i,
        output head_i,
        output tail_i,
        output out_ready_i,
        input  grant_o,
        input  out_valid_o
    );

    // Allocator side.
    modport slave (
        input  req_i,
        input  head_i,
        input  tail_i,
        input  out_ready_i,
        output grant_o,
        output out_valid_o
    );
endinterface

// File: rtl/noc_output_allocator.sv
// Wormhole output-port allocator: round-robin arbitration among head flits,
// packet-long lock from head to tail, and a stall watchdog that frees the port
// when the owning input stops supplying flits.
module noc_output_allocator #(
    parameter int N_REQ     = 5,
    parameter int MAX_STALL = 16,
    parameter int CNT_W     = 8
) (
    input  logic                       clk,
    input  logic                       arst,
    noc_output_allocator_if.slave      bus,
    output logic                       locked_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic [CNT_W-1:0]           flit_cnt_o,
    output logic                       timeout_o
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int STALL_W = (MAX_STALL > 1) ? $clog2(MAX_STALL + 1) : 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   flit_cnt_q, flit_cnt_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    logic [N_REQ-1:0]   cand;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic               locked;
    logic               owner_req;
    logic               owner_tail;
    logic               xfer;
    logic               tail_xfer;
    logic               stall_hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic [IDX_W-1:0]   next_ptr;
    logic [N_REQ-1:0]   grant;

    // (base + off) mod N_REQ, used for the round-robin scan and pointer advance.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Only head flits may open a packet; body/tail flits of unowned inputs never compete.
    assign cand = bus.req_i & bus.head_i;

    // Round-robin pick: first candidate at or above the pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && cand[wrap_add(rr_q, i)]) begin
                found  = 1'b1;
                winner = wrap_add(rr_q, i);
            end
        end
    end

    // Owner-side handshake, saturating counter increment and watchdog trip.
    always_comb begin
        locked     = (state_q == ST_LOCKED);
        owner_req  = bus.req_i[owner_q];
        owner_tail = bus.tail_i[owner_q];
        xfer       = locked && owner_req && bus.out_ready_i;
        tail_xfer  = xfer && owner_tail;
        cnt_inc    = (&flit_cnt_q) ? flit_cnt_q : flit_cnt_q + CNT_W'(1);
        next_ptr   = wrap_add(owner_q, 1);
        // Trips in the MAX_STALL-th consecutive cycle the owner shows no flit.
        stall_hit  = (MAX_STALL > 0) && locked && !owner_req &&
                     ((32'(stall_q) + 32'd1) == 32'(MAX_STALL));
    end

    // Next-state logic for the IDLE/LOCKED FSM and its counters.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        flit_cnt_d = flit_cnt_q;
        stall_d    = stall_q;
        case (state_q)
            ST_IDLE: begin
                flit_cnt_d = '0;
                stall_d    = '0;
                if (found) begin
                    state_d = ST_LOCKED;
                    owner_d = winner;
                end
            end
            ST_LOCKED: begin
                if (xfer) flit_cnt_d = cnt_inc;
                // Backpressure is not a stall: only a missing owner flit counts.
                if (owner_req)       stall_d = '0;
                else if (!(&stall_q)) stall_d = stall_q + STALL_W'(1);
                // Tail transfer and watchdog both release; the tail wins on ties.
                if (tail_xfer || stall_hit) begin
                    state_d    = ST_IDLE;
                    rr_d       = next_ptr;
                    owner_d    = '0;
                    flit_cnt_d = '0;
                    stall_d    = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                owner_d    = '0;
                flit_cnt_d = '0;
                stall_d    = '0;
            end
        endcase
    end

    // State registers; reset drops any lock immediately.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            owner_q    <= '0;
            flit_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            flit_cnt_q <= flit_cnt_d;
            stall_q    <= stall_d;
        end
    end

    // One-hot grant decoded from the registered owner while locked.
    always_comb begin
        grant = '0;
        if (locked) grant[owner_q] = 1'b1;
    end

    assign bus.grant_o     = grant;
    assign bus.out_valid_o = locked && owner_req;
    assign locked_o        = locked;
    assign owner_o         = owner_q;
    // Count includes the flit moving this cycle, so the tail cycle shows the packet length.
    assign flit_cnt_o      = xfer ? cnt_inc : flit_cnt_q;
    assign timeout_o       = stall_hit && !tail_xfer;

    // Structural invariants of the grant.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!arst) $onehot0(grant));
    a_grant_hold:   assert property (@(posedge clk) disable iff (!arst)
                                     (bus.out_valid_o && !bus.out_ready_i) |=> $stable(grant));

endmodule

// File: tb/tb_noc_output_allocator.sv
// Directed bench for noc_output_allocator: hand-computed transfers are queued
// by the stimulus and consumed by an independent negedge monitor.
module tb_noc_output_allocator;

  localparam int N_REQ     = 5;
  localparam int MAX_STALL = 16;
  localparam int CNT_W     = 8;
  localparam int W         = N_REQ + CNT_W;

  logic             clk;
  logic             arst;
  logic             locked;
  logic [2:0]       owner;
  logic [CNT_W-1:0] flit_cnt;
  logic             timeout;

  int checks;
  int passes;
  logic [W-1:0] exp_q[$];

  noc_output_allocator_if #(.N_REQ(N_REQ)) bus ();

  noc_output_allocator #(
    .N_REQ(N_REQ),
    .MAX_STALL(MAX_STALL),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .arst(arst),
    .bus(bus),
    .locked_o(locked),
    .owner_o(owner),
    .flit_cnt_o(flit_cnt),
    .timeout_o(timeout)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] all_outs();
    return {13'd0, bus.grant_o, bus.out_valid_o, locked, owner, flit_cnt, timeout};
  endfunction

  task automatic push_exp(input logic [N_REQ-1:0] g, input logic [CNT_W-1:0] c);
    exp_q.push_back({g, c});
  endtask

  // driver: one cycle of input vectors, outputs settled on return
  task automatic drive(input logic [N_REQ-1:0] req, input logic [N_REQ-1:0] head,
                       input logic [N_REQ-1:0] tail, input logic rdy);
    @(posedge clk);
    #1;
    bus.req_i       = req;
    bus.head_i      = head;
    bus.tail_i      = tail;
    bus.out_ready_i = rdy;
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    checks++;
    if ($onehot0(bus.grant_o)) passes++;
    else $display("FAIL grant_onehot: got 0x%0h expected onehot0", bus.grant_o);
    if (bus.out_valid_o && bus.out_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got grant=0x%0h cnt=%0d expected no transfer",
                 bus.grant_o, flit_cnt);
      end else begin
        e = exp_q.pop_front();
        if ({bus.grant_o, flit_cnt} === e) passes++;
        else $display("FAIL sb_xfer: got grant=0x%0h cnt=%0d expected grant=0x%0h cnt=%0d",
                      bus.grant_o, flit_cnt, e[W-1:CNT_W], e[CNT_W-1:0]);
      end
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    arst   = 1'b1;
    bus.req_i = '0; bus.head_i = '0; bus.tail_i = '0; bus.out_ready_i = 1'b0;
    #2 arst = 1'b0;

    // reset then idle
    repeat (3) drive(5'b0, 5'b0, 5'b0, 1'b0);
    check("rst_outs_in_reset", all_outs(), 32'd0);
    @(posedge clk);
    #1 arst = 1'b1;
    #1 check("rst_outs_first_cycle", all_outs(), 32'd0);

    // single requester, 4-flit packet from input 2
    for (int k = 1; k <= 4; k++) push_exp(5'b00100, CNT_W'(k));
    drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
    check("single_arb_cycle_grant", bus.grant_o, 5'b00000);
    drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
    check("single_head_grant", bus.grant_o, 5'b00100);
    check("single_owner", owner, 3'd2);
    drive(5'b00100, 5'b00000, 5'b00000, 1'b1);
    drive(5'b00100, 5'b00000, 5'b00000, 1'b1);
    drive(5'b00100, 5'b00000, 5'b00100, 1'b1);
    check("single_tail_grant", bus.grant_o, 5'b00100);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
    check("single_idle_after", {locked, flit_cnt, owner}, 32'd0);

    // fairness: inputs 0 and 3, pointer now 3 so input 3 goes first
    push_exp(5'b01000, 8'd1); push_exp(5'b01000, 8'd2);
    push_exp(5'b00001, 8'd1); push_exp(5'b00001, 8'd2);
    push_exp(5'b01000, 8'd1); push_exp(5'b01000, 8'd2);
    push_exp(5'b00001, 8'd1); push_exp(5'b00001, 8'd2);
    drive(5'b01001, 5'b01001, 5'b00000, 1'b1);
    check("fair_arb0", bus.grant_o, 5'b00000);
    drive(5'b01001, 5'b01001, 5'b00000, 1'b1);
    check("fair_grant3a", bus.grant_o, 5'b01000);
    drive(5'b01001, 5'b00001, 5'b01000, 1'b1);
    drive(5'b01001, 5'b01001, 5'b00000, 1'b1);
    check("fair_bubble1", bus.grant_o, 5'b00000);
    drive(5'b01001, 5'b01001, 5'b00000, 1'b1);
    check("fair_grant0a", bus.grant_o, 5'b00001);
    drive(5'b01001, 5'b01000, 5'b00001, 1'b1);
    drive(5'b01001, 5'b01001, 5'b00000, 1'b1);
    check("fair_bubble2", bus.grant_o, 5'b00000);
    drive(5'b01001, 5'b01001, 5'b00000, 1'b1);
    check("fair_grant3b", bus.grant_o, 5'b01000);
    drive(5'b01001, 5'b00001, 5'b01000, 1'b1);
    drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
    check("fair_bubble3", bus.grant_o, 5'b00000);
    drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
    check("fair_grant0b", bus.grant_o, 5'b00001);
    drive(5'b00001, 5'b00000, 5'b00001, 1'b1);

    // mid-packet head from input 1 waits; then a single-flit packet
    push_exp(5'b00100, 8'd1); push_exp(5'b00100, 8'd2); push_exp(5'b00100, 8'd3);
    push_exp(5'b00010, 8'd1);
    drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
    drive(5'b00110, 5'b00110, 5'b00000, 1'b1);
    check("mid_head_ignored1", bus.grant_o, 5'b00100);
    drive(5'b00110, 5'b00010, 5'b00000, 1'b1);
    check("mid_head_ignored2", bus.grant_o, 5'b00100);
    drive(5'b00110, 5'b00010, 5'b00100, 1'b1);
    drive(5'b00010, 5'b00010, 5'b00000, 1'b1);
    check("mid_bubble", {bus.grant_o, locked}, 32'd0);
    drive(5'b00010, 5'b00010, 5'b00010, 1'b1);
    check("one_flit_locked", {bus.grant_o, locked}, {26'd0, 5'b00010, 1'b1});
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
    check("one_flit_released", locked, 1'b0);

    // backpressure: owner valid, ready low for 20 cycles
    push_exp(5'b00100, 8'd1); push_exp(5'b00100, 8'd2);
    drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
    drive(5'b00100, 5'b00100, 5'b00000, 1'b1);
    for (int k = 0; k < 20; k++) begin
      drive(5'b00100, 5'b00000, 5'b00000, 1'b0);
      check("bp_state", {bus.grant_o, bus.out_valid_o, timeout, flit_cnt},
            {16'd0, 5'b00100, 1'b1, 1'b0, 8'd1});
    end
    drive(5'b00100, 5'b00000, 5'b00100, 1'b1);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);

    // watchdog: owner 4 sends head then goes silent
    push_exp(5'b10000, 8'd1); push_exp(5'b00001, 8'd1); push_exp(5'b10000, 8'd1);
    drive(5'b10000, 5'b10000, 5'b00000, 1'b1);
    drive(5'b10000, 5'b10000, 5'b00000, 1'b1);
    for (int k = 1; k <= MAX_STALL; k++) begin
      drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
      check("wd_timeout", {locked, timeout}, (k == MAX_STALL) ? 32'd3 : 32'd2);
    end
    drive(5'b10001, 5'b10001, 5'b00000, 1'b1);
    check("wd_idle_after", {locked, timeout, owner}, 32'd0);
    drive(5'b10001, 5'b10001, 5'b00001, 1'b1);
    check("wd_ptr_wrap0", bus.grant_o, 5'b00001);
    drive(5'b10000, 5'b10000, 5'b10000, 1'b1);
    drive(5'b10000, 5'b10000, 5'b10000, 1'b1);
    check("wd_then4", bus.grant_o, 5'b10000);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);

    // flit counter saturation: 300-flit packet from input 0
    for (int k = 1; k <= 300; k++) push_exp(5'b00001, (k > 255) ? 8'd255 : CNT_W'(k));
    drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
    drive(5'b00001, 5'b00001, 5'b00000, 1'b1);
    for (int k = 2; k < 300; k++) drive(5'b00001, 5'b00000, 5'b00000, 1'b1);
    drive(5'b00001, 5'b00000, 5'b00001, 1'b1);
    check("sat_tail_cnt", flit_cnt, 8'd255);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
    check("sat_cleared", flit_cnt, 8'd0);

    // async reset between a body flit and the tail
    push_exp(5'b00010, 8'd1); push_exp(5'b00010, 8'd2); push_exp(5'b01000, 8'd1);
    drive(5'b00010, 5'b00010, 5'b00000, 1'b1);
    drive(5'b00010, 5'b00010, 5'b00000, 1'b1);
    drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
    drive(5'b00010, 5'b00000, 5'b00000, 1'b0);
    check("ar_locked_before", bus.grant_o, 5'b00010);
    arst = 1'b0;
    #1;
    check("ar_drop_no_edge", all_outs(), 32'd0);
    repeat (2) drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
    @(posedge clk);
    #1 arst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(5'b00010, 5'b00000, 5'b00000, 1'b1);
      check("ar_body_not_granted", {bus.grant_o, locked}, 32'd0);
    end
    drive(5'b01010, 5'b01000, 5'b01000, 1'b1);
    drive(5'b01010, 5'b01000, 5'b01000, 1'b1);
    check("ar_new_head_granted", bus.grant_o, 5'b01000);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);
    drive(5'b00000, 5'b00000, 5'b00000, 1'b1);

    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
